// File: rtl/pb_cond_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package pb_cond_pkg;

    // Auto-repeat state of one channel.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_chan.sv
// One button channel: synchroniser, tick-driven debounce, edge pulses and
// the long-press auto-repeat FSM.
//
// Handshake note: there is no valid/ready traffic here; every output is a
// registered level or a single-cycle strobe that consumers sample on clk.
module pb_chan
    import pb_cond_pkg::*;
#(
    parameter int STABLE       = 4,
    parameter int HOLD_TICKS   = 250,
    parameter int REPEAT_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       pb,
    input  logic       repeat_en,
    output logic       pb_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output rpt_state_t state
);

    localparam int SW = clog2_min1(STABLE);
    localparam int RW = clog2_min1(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE - 1);
    localparam logic [RW-1:0] HOLD_MAX    = RW'(HOLD_TICKS);
    localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST    = RW'(REPEAT_TICKS - 1);

    logic          sync1, sync2;
    logic [SW-1:0] stable_cnt;
    logic          differ, flip, rise, fall;

    rpt_state_t    state_q, state_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_fire;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pb;
            sync2 <= sync1;
        end
    end

    // A flip happens on the STABLE-th consecutive disagreeing tick.
    assign differ = (sync2 != pb_level);
    assign flip   = tick && differ && (stable_cnt == STABLE_LAST);
    assign rise   = flip && sync2;
    assign fall   = flip && !sync2;

    // Debounce counter and debounced level; any agreeing tick restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            pb_level   <= 1'b0;
        end else if (tick) begin
            if (!differ) begin
                stable_cnt <= '0;
            end else if (stable_cnt == STABLE_LAST) begin
                pb_level   <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    // Pulse registers line up with the cycle pb_level shows its new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= rise;
            release_pulse <= fall;
            repeat_pulse  <= rpt_fire;
        end
    end

    // Auto-repeat state and tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Auto-repeat next state; a release on the same tick overrides a due repeat.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (tick) begin
            if (fall) begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_d   = HOLD;
                            rpt_cnt_d = '0;
                        end
                    end
                    HOLD: begin
                        // Count saturates at HOLD_TICKS while repeat is disabled.
                        if (rpt_cnt_q >= HOLD_LAST) begin
                            if (repeat_en) begin
                                state_d   = REPEAT;
                                rpt_cnt_d = '0;
                                rpt_fire  = 1'b1;
                            end else begin
                                rpt_cnt_d = HOLD_MAX;
                            end
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!repeat_en) begin
                            state_d   = HOLD;
                            rpt_cnt_d = HOLD_MAX;
                        end else if (rpt_cnt_q >= REP_LAST) begin
                            rpt_cnt_d = '0;
                            rpt_fire  = 1'b1;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pb_conditioner.sv
// Multi-channel push-button conditioner: shared sample-tick prescaler,
// one pb_chan per button and a registered "any event" strobe.
module pb_conditioner
    import pb_cond_pkg::*;
#(
    parameter int CH           = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE       = 4,
    parameter int HOLD_TICKS   = 250,
    parameter int REPEAT_TICKS = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   pb,
    input  logic [CH-1:0]   repeat_en,
    output logic [CH-1:0]   pb_level,
    output logic [CH-1:0]   press_pulse,
    output logic [CH-1:0]   release_pulse,
    output logic [CH-1:0]   repeat_pulse,
    output logic            event_any,
    output logic [2*CH-1:0] dbg_state
);

    localparam int PW = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_cnt;
    logic          tick;

    assign tick = (presc_cnt == TICK_LAST);

    // Free-running prescaler, wraps after TICK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        rpt_state_t chan_state;

        pb_chan #(
            .STABLE       (STABLE),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (tick),
            .pb            (pb[g]),
            .repeat_en     (repeat_en[g]),
            .pb_level      (pb_level[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .repeat_pulse  (repeat_pulse[g]),
            .state         (chan_state)
        );

        assign dbg_state[2*g +: 2] = chan_state;
    end

    // One-cycle-late OR of every press and repeat strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_any <= 1'b0;
        end else begin
            event_any <= |(press_pulse | repeat_pulse);
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with a small tick period.
module tb_pb_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pb;
  logic [3:0] repeat_en;
  logic [3:0] pb_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] repeat_pulse;
  logic       event_any;
  logic [7:0] dbg_state;

  int checks = 0;
  int errors = 0;

  pb_conditioner #(
    .CH(4), .TICK_DIV(4), .STABLE(3), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb(pb), .repeat_en(repeat_en),
    .pb_level(pb_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .event_any(event_any), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // event monitor: counts pulses and records the edge number of the latest one
  int cyc = 0;
  int press_cnt[4], rel_cnt[4], rep_cnt[4];
  int last_press[4], last_rel[4], last_rep[4], prev_rep[4];
  int wide = 0;
  logic prev_any = 1'b0;
  logic [3:0] prev_p = '0, prev_r = '0, prev_q = '0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; rep_cnt[i] = 0;
      last_press[i] = 0; last_rel[i] = 0; last_rep[i] = 0; prev_rep[i] = 0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst_n) begin
      prev_any = 1'b0;
      prev_p = '0; prev_r = '0; prev_q = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (press_pulse[i]) begin press_cnt[i]++; last_press[i] = cyc; end
        if (release_pulse[i]) begin rel_cnt[i]++; last_rel[i] = cyc; end
        if (repeat_pulse[i]) begin rep_cnt[i]++; prev_rep[i] = last_rep[i]; last_rep[i] = cyc; end
      end
      if (((press_pulse & prev_p) | (release_pulse & prev_r) | (repeat_pulse & prev_q)) != '0)
        wide++;
      if (prev_any || event_any) begin
        checks++;
        assert (event_any === prev_any) else begin
          errors++;
          $error("FAIL event_any @%0d: observed %0b expected %0b", cyc, event_any, prev_any);
        end
      end
      prev_any = |(press_pulse | repeat_pulse);
      prev_p = press_pulse; prev_r = release_pulse; prev_q = repeat_pulse;
    end
  end

  // driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a new press on channel ch; returns its edge number.
  task automatic wait_press(input int ch, input int base, output int p);
    bit seen = 0;
    p = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (press_cnt[ch] != base) begin
        seen = 1;
        p = last_press[ch];
      end
    end
    chk($sformatf("press_seen_ch%0d", ch), seen ? 32'd1 : 32'd0, 32'd1);
  endtask

  int bp[4], br[4], bq[4];
  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      bp[i] = press_cnt[i]; br[i] = rel_cnt[i]; bq[i] = rep_cnt[i];
    end
  endtask

  int rel_cyc, p, n;

  initial begin
    rst_n = 1'b0;
    pb = '0;
    repeat_en = '0;
    #1;
    chk("rst_level", 32'(pb_level), 0);
    chk("rst_pulses", 32'({press_pulse, release_pulse, repeat_pulse}), 0);
    chk("rst_event", 32'(event_any), 0);
    chk("rst_state", 32'(dbg_state), 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    // 1: reset mid-operation with all buttons held
    pb = 4'hF;
    cycles(30);
    chk("t1_level_held", 32'(pb_level), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_level", 32'(pb_level), 0);
    chk("t1_async_pulses", 32'({press_pulse, release_pulse, repeat_pulse}), 0);
    chk("t1_async_event", 32'(event_any), 0);
    chk("t1_async_state", 32'(dbg_state), 0);
    cycles(3);
    snap();
    rst_n = 1'b1;
    rel_cyc = cyc;
    cycles(20);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_press_ch%0d", i), 32'(press_cnt[i] - bp[i]), 1);
      n = last_press[i] - rel_cyc;
      chk($sformatf("t1_latency_ch%0d", i), (n >= 11 && n <= 15) ? 32'd1 : 32'd0, 1);
      chk($sformatf("t1_no_rel_ch%0d", i), 32'(rel_cnt[i] - br[i]), 0);
    end
    chk("t1_level_after", 32'(pb_level), 32'hF);
    pb = 4'h0;
    cycles(20);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_release_ch%0d", i), 32'(rel_cnt[i] - br[i]), 1);
    chk("t1_level_low", 32'(pb_level), 0);

    // 2: bounce rejection on channel 0
    snap();
    for (int k = 0; k < 20; k++) begin
      pb[0] = ~pb[0];
      cycles(3);
    end
    chk("t2_bounce_press", 32'(press_cnt[0] - bp[0]), 0);
    chk("t2_bounce_rel", 32'(rel_cnt[0] - br[0]), 0);
    pb[0] = 1'b1;
    cycles(20);
    chk("t2_settled_press", 32'(press_cnt[0] - bp[0]), 1);
    chk("t2_level0", 32'(pb_level[0]), 1);
    for (int i = 1; i < 4; i++)
      chk($sformatf("t2_silent_ch%0d", i),
          32'(press_cnt[i] - bp[i] + rel_cnt[i] - br[i] + rep_cnt[i] - bq[i]), 0);
    pb[0] = 1'b0;
    cycles(20);
    chk("t2_release0", 32'(rel_cnt[0] - br[0]), 1);

    // 3: short glitch on channel 1
    snap();
    pb[1] = 1'b1;
    cycles(8);
    pb[1] = 1'b0;
    cycles(20);
    chk("t3_level1", 32'(pb_level[1]), 0);
    chk("t3_press1", 32'(press_cnt[1] - bp[1]), 0);
    chk("t3_rel1", 32'(rel_cnt[1] - br[1]), 0);

    // 4: auto-repeat on channel 2
    repeat_en[2] = 1'b1;
    snap();
    pb[2] = 1'b1;
    wait_press(2, bp[2], p);
    cycles(21);
    chk("t4_first_rep_cnt", 32'(rep_cnt[2] - bq[2]), 1);
    chk("t4_first_rep_gap", 32'(last_rep[2] - p), 20);
    cycles(24);
    chk("t4_rep_cnt", 32'(rep_cnt[2] - bq[2]), 4);
    chk("t4_rep_last", 32'(last_rep[2] - p), 44);
    chk("t4_rep_period", 32'(last_rep[2] - prev_rep[2]), 8);
    pb[2] = 1'b0;
    cycles(20);
    chk("t4_release", 32'(rel_cnt[2] - br[2]), 1);
    chk("t4_rep_before_rel", (last_rep[2] < last_rel[2]) ? 32'd1 : 32'd0, 1);
    snap();
    cycles(24);
    chk("t4_no_rep_after", 32'(rep_cnt[2] - bq[2]), 0);

    // 5: repeat enable gating on channel 3
    snap();
    pb[3] = 1'b1;
    wait_press(3, bp[3], p);
    cycles(100);
    chk("t5_no_rep_disabled", 32'(rep_cnt[3] - bq[3]), 0);
    repeat_en[3] = 1'b1;
    cycles(4);
    chk("t5_rep_next_tick", 32'(rep_cnt[3] - bq[3]), 1);
    cycles(16);
    chk("t5_rep_cnt", 32'(rep_cnt[3] - bq[3]), 3);
    chk("t5_rep_period", 32'(last_rep[3] - prev_rep[3]), 8);
    repeat_en[3] = 1'b0;
    snap();
    cycles(40);
    chk("t5_rep_stopped", 32'(rep_cnt[3] - bq[3]), 0);
    chk("t5_still_held", 32'(pb_level[3]), 1);
    pb[3] = 1'b0;
    cycles(20);
    chk("t5_release", 32'(rel_cnt[3] - br[3]), 1);

    // 6: release lands on a repeat-due tick (channel 2, repeat enabled)
    snap();
    pb[2] = 1'b1;
    wait_press(2, bp[2], p);
    cycles(24);
    pb[2] = 1'b0;
    cycles(20);
    chk("t6_release", 32'(rel_cnt[2] - br[2]), 1);
    chk("t6_release_at", 32'(last_rel[2] - p), 36);
    chk("t6_rep_cnt", 32'(rep_cnt[2] - bq[2]), 2);
    chk("t6_rep_last", 32'(last_rep[2] - p), 28);
    chk("t6_state_idle", 32'(dbg_state), 0);

    chk("pulse_width", 32'(wide), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
